// File: rtl/alu_issue_if.sv
// Issue-side bundle for alu_issue: instruction handshake, ALU operand/result,
// writeback observation, debug read port and retire counter.
interface alu_issue_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    logic [31:0] alu_res;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [15:0] retire_cnt;

    // The issue block itself.
    modport slave (
        input  instr_valid, instr, alu_res, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_shamt, alu_funct,
               wb_valid, wb_addr, wb_data, dbg_data, retire_cnt
    );

    // Instruction source plus the ALU/debug side around the block.
    modport master (
        output instr_valid, instr, alu_res, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_shamt, alu_funct,
               wb_valid, wb_addr, wb_data, dbg_data, retire_cnt
    );
endinterface

// File: rtl/alu_issue.sv
// Single-issue front end for an external registered ALU: owns a 32x32
// register file, issues one instruction at a time (IDLE -> EXEC -> WB, or
// IDLE -> WB for load-immediate) and retires it by writing R[rd].
module alu_issue (
    input  logic       clk,
    input  logic       rst,
    alu_issue_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [4:0]  alu_shamt_q, alu_shamt_d;
    logic [3:0]  alu_funct_q, alu_funct_d;
    logic [4:0]  rd_q, rd_d;
    logic        ldi_q, ldi_d;
    logic [31:0] imm_q, imm_d;
    logic [15:0] retire_cnt_q, retire_cnt_d;
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Instruction field decode; only meaningful on the accept cycle.
    logic [3:0]  in_funct;
    logic [4:0]  in_rd, in_rs, in_rt, in_shamt;
    logic [17:0] in_imm;
    logic        accept;
    logic [31:0] wb_value;

    assign in_funct = bus.instr[31:28];
    assign in_rd    = bus.instr[27:23];
    assign in_rs    = bus.instr[22:18];
    assign in_rt    = bus.instr[17:13];
    assign in_shamt = bus.instr[12:8];
    assign in_imm   = bus.instr[17:0];
    assign accept   = bus.instr_valid && (state_q == S_IDLE);

    // The ALU result is already registered by the ALU at the EXEC->WB edge.
    assign wb_value = ldi_q ? imm_q : bus.alu_res;

    // Next-state, operand latch, retire and register-file write logic.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_shamt_d  = alu_shamt_q;
        alu_funct_d  = alu_funct_q;
        rd_d         = rd_q;
        ldi_d        = ldi_q;
        imm_d        = imm_q;
        retire_cnt_d = retire_cnt_q;
        regs_d       = regs_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rd_d = in_rd;
                    if (in_funct == 4'd0) begin
                        // LDI bypasses the ALU; operand outputs stay put.
                        ldi_d   = 1'b1;
                        imm_d   = {14'b0, in_imm};
                        state_d = S_WB;
                    end else begin
                        ldi_d       = 1'b0;
                        alu_a_d     = regs_q[in_rs];
                        alu_b_d     = regs_q[in_rt];
                        alu_shamt_d = in_shamt;
                        alu_funct_d = in_funct;
                        state_d     = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_WB;
            end
            S_WB: begin
                // Park the ALU on funct 0 so it keeps its last result.
                alu_funct_d  = 4'd0;
                retire_cnt_d = retire_cnt_q + 16'd1;
                if (rd_q != 5'd0) begin
                    regs_d[rd_q] = wb_value;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset also aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shamt_q  <= '0;
            alu_funct_q  <= '0;
            rd_q         <= '0;
            ldi_q        <= 1'b0;
            imm_q        <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_shamt_q  <= alu_shamt_d;
            alu_funct_q  <= alu_funct_d;
            rd_q         <= rd_d;
            ldi_q        <= ldi_d;
            imm_q        <= imm_d;
            retire_cnt_q <= retire_cnt_d;
            regs_q       <= regs_d;
        end
    end

    assign bus.instr_ready = (state_q == S_IDLE);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_shamt   = alu_shamt_q;
    assign bus.alu_funct   = alu_funct_q;
    assign bus.wb_valid    = (state_q == S_WB);
    assign bus.wb_addr     = (state_q == S_WB) ? rd_q : 5'd0;
    assign bus.wb_data     = (state_q == S_WB) ? wb_value : 32'd0;
    // R0 is never written, so it reads as zero here and on the operand path.
    assign bus.dbg_data    = regs_q[bus.dbg_addr];
    assign bus.retire_cnt  = retire_cnt_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small registered ALU model on the side.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int wb_pulses = 0;

    // Captures from the most recent exec_instr call.
    int          lat;
    int          wb_seen;
    logic [31:0] snap_a, snap_b, wb_d;
    logic [4:0]  snap_sh, wb_sh, wb_a;
    logic [3:0]  snap_fn;
    logic [8:0]  rdy_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (f)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd8:    return a << sh;
            default: return a ^ b;
        endcase
    endfunction

    // Registered ALU: captures a result on every edge with a nonzero funct.
    always @(posedge clk) begin
        if (rst) bus.alu_res <= 32'd0;
        else if (bus.alu_funct != 4'd0)
            bus.alu_res <= alu_ref(bus.alu_funct, bus.alu_a, bus.alu_b, bus.alu_shamt);
    end

    always @(negedge clk) begin
        if (bus.wb_valid === 1'b1) wb_pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] op(input logic [3:0] f, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] sh);
        return {f, rd, rs, rt, sh, 8'h00};
    endfunction

    function automatic logic [31:0] ldi(input logic [4:0] rd, input logic [17:0] imm);
        return {4'h0, rd, 5'd0, imm};
    endfunction

    // Offer one word for a single cycle, then follow it to completion.
    // lat counts edges from accept until instr_ready returns.
    task automatic exec_instr(input logic [31:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
        lat     = 1;
        wb_seen = 0;
        snap_a  = bus.alu_a;
        snap_b  = bus.alu_b;
        snap_sh = bus.alu_shamt;
        snap_fn = bus.alu_funct;
        while (!bus.instr_ready && lat < 8) begin
            if (bus.wb_valid) begin
                wb_seen++;
                wb_a  = bus.wb_addr;
                wb_d  = bus.wb_data;
                wb_sh = bus.alu_shamt;
            end
            tick();
            lat++;
        end
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.dbg_addr = a;
        #1;
        chk(tag, bus.dbg_data, exp);
    endtask

    initial begin
        rst             = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = 32'd0;
        bus.dbg_addr    = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_shamt", 32'(bus.alu_shamt), 32'd0);
        chk("rst_funct", 32'(bus.alu_funct), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_retire", 32'(bus.retire_cnt), 32'd0);
        chk_reg("rst_r5", 5'd5, 32'd0);

        // LDI r1=5, LDI r2=7, ADD r3=r1+r2
        wb_pulses = 0;
        exec_instr(ldi(5'd1, 18'd5));
        chk("ldi_lat", 32'(lat), 32'd2);
        chk("ldi_wb_addr", 32'(wb_a), 32'd1);
        chk("ldi_wb_data", wb_d, 32'd5);
        exec_instr(ldi(5'd2, 18'd7));
        exec_instr(op(4'd1, 5'd3, 5'd1, 5'd2, 5'd0));
        chk("add_lat", 32'(lat), 32'd3);
        chk("add_exec_a", snap_a, 32'd5);
        chk("add_exec_b", snap_b, 32'd7);
        chk("add_exec_funct", 32'(snap_fn), 32'd1);
        chk("add_wb_data", wb_d, 32'd12);
        chk_reg("add_r3", 5'd3, 32'd12);
        chk("add_wb_pulses", 32'(wb_pulses), 32'd3);
        chk("add_retire", 32'(bus.retire_cnt), 32'd3);
        chk("idle_funct_zero", 32'(bus.alu_funct), 32'd0);

        // LDI r1=3, SLA r4=r1<<4, SUB r5=r1-r4
        exec_instr(ldi(5'd1, 18'd3));
        exec_instr(op(4'd8, 5'd4, 5'd1, 5'd0, 5'd4));
        chk("sla_exec_shamt", 32'(snap_sh), 32'd4);
        chk("sla_exec_funct", 32'(snap_fn), 32'd8);
        chk("sla_wb_shamt", 32'(wb_sh), 32'd4);
        chk_reg("sla_r4", 5'd4, 32'd48);
        exec_instr(op(4'd2, 5'd5, 5'd1, 5'd4, 5'd0));
        chk_reg("sub_r5", 5'd5, 32'hFFFF_FFD3);
        chk("sub_retire", 32'(bus.retire_cnt), 32'd6);

        // Back-to-back: r8 += r1 (3) with valid held high for 9 cycles
        bus.instr       = op(4'd1, 5'd8, 5'd8, 5'd1, 5'd0);
        bus.instr_valid = 1'b1;
        rdy_bits        = '0;
        for (int i = 0; i < 9; i++) begin
            rdy_bits[i] = bus.instr_ready;
            tick();
        end
        bus.instr_valid = 1'b0;
        chk("b2b_ready_pattern", 32'(rdy_bits), 32'h049);
        chk_reg("b2b_r8", 5'd8, 32'd9);
        chk("b2b_retire", 32'(bus.retire_cnt), 32'd9);

        // R0 stays zero
        exec_instr(ldi(5'd0, 18'h3FFFF));
        chk("r0_wb_seen", 32'(wb_seen), 32'd1);
        chk("r0_wb_addr", 32'(wb_a), 32'd0);
        chk("r0_wb_data", wb_d, 32'h0003_FFFF);
        chk_reg("r0_read", 5'd0, 32'd0);
        exec_instr(ldi(5'd6, 18'h123));
        chk_reg("r6_pre", 5'd6, 32'h123);
        exec_instr(op(4'd1, 5'd6, 5'd0, 5'd0, 5'd0));
        chk("r0_operand", snap_a, 32'd0);
        chk_reg("r6_zero", 5'd6, 32'd0);
        chk("r0_retire", 32'(bus.retire_cnt), 32'd12);

        // Reset during EXEC aborts; reset also beats a pending instr_valid
        bus.instr       = op(4'd1, 5'd7, 5'd1, 5'd2, 5'd0);
        bus.instr_valid = 1'b1;
        tick();
        chk("abort_in_exec", 32'(bus.instr_ready), 32'd0);
        rst       = 1'b1;
        bus.instr = ldi(5'd9, 18'd1);
        tick();
        tick();
        rst             = 1'b0;
        bus.instr_valid = 1'b0;
        chk("abort_ready", 32'(bus.instr_ready), 32'd1);
        chk("abort_retire", 32'(bus.retire_cnt), 32'd0);
        chk("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("abort_alu_a", bus.alu_a, 32'd0);
        chk_reg("abort_r7", 5'd7, 32'd0);
        chk_reg("abort_r9", 5'd9, 32'd0);
        chk_reg("abort_r1", 5'd1, 32'd0);
        exec_instr(ldi(5'd9, 18'd2));
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk_reg("post_rst_r9", 5'd9, 32'd2);

        // Retire counter wrap, counter preloaded to 0xFFFF
        force dut.retire_cnt_q = 16'hFFFF;
        tick();
        release dut.retire_cnt_q;
        #1;
        chk("wrap_preload", 32'(bus.retire_cnt), 32'h0000_FFFF);
        exec_instr(ldi(5'd10, 18'h2AAAA));
        chk("wrap_retire", 32'(bus.retire_cnt), 32'd0);
        chk_reg("wrap_r10", 5'd10, 32'h0002_AAAA);
        chk_reg("wrap_r9", 5'd9, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Backstop so the bench always ends even if the flow above stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: none; all widths fixed (32-entry x 32-bit register file, 4-bit funct, 5-bit shamt).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 instr_valid  input  1  instruction word offered.
REQ-005 instr  input  32  [31:28] funct, [27:23] rd, [22:18] rs, [17:13] rt, [12:8] shamt, [17:0] imm (funct 0 only), [7:0] ignored otherwise.
REQ-006 instr_ready  output  1  block accepts instr this cycle.
REQ-007 alu_a / alu_b  output  32 each  operands to the downstream ALU (a = R[rs], b = R[rt]).
REQ-008 alu_shamt  output  5  shift amount to ALU.
REQ-009 alu_funct  output  4  ALU op code (1 ADD .. 15 HAM; 0 never driven to ALU except at reset/idle).
REQ-010 alu_res  input  32  ALU result, registered inside the ALU on posedge clk.
REQ-011 wb_valid  output  1  pulse: register write occurring this cycle.
REQ-012 wb_addr / wb_data  output  5 / 32  destination and value being written.
REQ-013 dbg_addr  input  5  debug read address; dbg_data  output  32  asynchronous read of R[dbg_addr].
REQ-014 retire_cnt  output  16  count of completed instructions.

Function
REQ-015 States IDLE, EXEC, WB; instr_ready SHALL be 1 only in IDLE.
REQ-016 Accept = instr_valid & instr_ready; on accept with funct != 0: alu_a <= R[rs], alu_b <= R[rt], alu_shamt, alu_funct, latched rd; next state EXEC.
REQ-017 On accept with funct == 0 (LDI): wb data latched = {14'b0, imm[17:0]}; next state WB directly; alu_* outputs unchanged.
REQ-018 EXEC lasts exactly 1 cycle; alu_a/b/shamt/funct SHALL hold stable through EXEC so the ALU captures res at the EXEC->WB edge; next state WB.
REQ-019 WB lasts exactly 1 cycle: wb_valid = 1, wb_addr = rd, wb_data = alu_res (ALU ops) or latched imm (LDI); R[rd] <= wb_data at the WB->IDLE edge; retire_cnt += 1 at same edge; next state IDLE.
REQ-020 Latency: ALU op accept to register update = 3 edges; LDI = 2 edges; max throughput 1 instr / 3 cycles (ALU) or 1 / 2 (LDI).
REQ-021 R0 SHALL read as 0 on all ports; writes with rd = 0 still assert wb_valid and retire but leave R0 = 0.
REQ-022 No bypass needed: a write completes before the next accept, so an instruction reading the previous rd sees the new value.
REQ-023 instr_valid in EXEC/WB SHALL be ignored (instr_ready = 0); instr is sampled only at accept.
REQ-024 retire_cnt wraps 16'hFFFF -> 16'h0000 without side effects.
REQ-025 alu_funct SHALL be forced to 0 in IDLE after WB so the ALU holds its last res (no ALU op on funct 0).
REQ-026 dbg_data reflects a register write from the cycle after the write edge.

Reset
REQ-027 On rst = 1 at posedge: state IDLE, all R[0..31] = 0, alu_a/alu_b/alu_shamt/alu_funct = 0, wb_valid = 0, wb_addr = 0, wb_data = 0, retire_cnt = 0.
REQ-028 rst in EXEC or WB SHALL abort the instruction: no register write, no retire increment.
REQ-029 rst dominates a simultaneous instr_valid; instr_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-030 LDI r1 imm=5, LDI r2 imm=7, ADD(1) rd=3 rs=1 rt=2 -> R3 = 12, wb_valid pulses 3 times, retire_cnt = 3.
REQ-031 LDI r1 = 3, SLA(8) rd=4 rs=1 shamt=4 -> alu_shamt = 4 stable through EXEC, R4 = 48; SUB(2) rd=5 rs=1 rt=4 -> R5 = 0xFFFFFFD3.
REQ-032 instr_valid held high with back-to-back ADDs -> instr_ready = 1 only every 3rd cycle; each accepted word executed exactly once.
REQ-033 LDI r0 imm=0x3FFFF -> wb_valid = 1, wb_data = 0x3FFFF, dbg_addr=0 reads 0; ADD rd=6 rs=0 rt=0 -> R6 = 0.
REQ-034 rst asserted during EXEC of ADD rd=7 -> R7 stays 0, retire_cnt = 0, instr_ready = 1 the cycle after rst drops.
REQ-035 Preload retire_cnt to 0xFFFF via 65535 LDIs (or force), one more LDI -> retire_cnt = 0x0000.
